// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package serial_tx_pkg;

    localparam int WIDTH_DEF = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/serial_pattern_tx.sv
// Parallel-in, LSB-first serial transmitter with a valid/ready handshake.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] word,
    input  logic             valid,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             out_q, out_d;
    logic             accept;
    logic             last_bit;
    logic             frame_end;

    assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign accept   = valid && ready;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q, par_d;
    assign frame_end = (state_q == PARITY);
`else
    assign frame_end = last_bit;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: begin
                if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_d = accept ? SHIFT : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Handshake and framing outputs
    always_comb begin
        ready     = (state_q == IDLE) || frame_end;
        done      = frame_end;
        out_valid = (state_q != IDLE);
    end

    // Datapath: out_q holds the bit on the wire, sr_q[0] is the next one
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        out_d = out_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d = par_q;
`endif
        if (accept) begin
            sr_d  = word >> 1;
            out_d = word[0];
            cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            par_d = ^word;
`endif
        end else if ((state_q == SHIFT) && !last_bit) begin
            sr_d  = sr_q >> 1;
            out_d = sr_q[0];
            cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_TX_PARITY_EN
        end else if (last_bit) begin
            out_d = par_q;
`endif
        end else begin
            out_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif

    assign out = out_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: vector table plus multi-cycle corner sequences.
module tb_serial_pattern_tx;
    import serial_tx_pkg::*;

    localparam int W = 14;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] word = '0;
    logic         valid = 1'b0;
    logic         ready, out, out_valid, done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] word;
        logic         valid;
        logic         e_out;
        logic         e_ov;
        logic         e_done;
        logic         e_ready;
    } vec_t;

    vec_t tv [FL+1];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .word      (word),
        .valid     (valid),
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[i];
        return ^w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assumes the next edge accepts w; drops valid after acceptance.
    task automatic expect_frame(input logic [W-1:0] w, input string nm);
        for (int i = 0; i < FL; i++) begin
            step();
            if (i == 0) valid = 1'b0;
            chk({nm, "_out"},  32'(out),       32'(exp_bit(w, i)));
            chk({nm, "_ov"},   32'(out_valid), 32'd1);
            chk({nm, "_done"}, 32'(done),      32'(i == FL - 1));
        end
        step();
        chk({nm, "_idle_ov"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] wj;
        logic [31:0]  got, expw;
        logic [2:0]   h_dut, h_ref;
        int           c_dut, c_ref;

        for (int i = 0; i <= FL; i++) begin
            tv[i].word    = W'(7);
            tv[i].valid   = (i == 0);
            tv[i].e_out   = (i < FL) ? exp_bit(W'(7), i) : 1'b0;
            tv[i].e_ov    = (i < FL);
            tv[i].e_done  = (i == FL - 1);
            tv[i].e_ready = (i >= FL - 1);
        end

        // Reset state
        #2;
        chk("rst_out",   32'(out),       32'd0);
        chk("rst_ov",    32'(out_valid), 32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_ready", 32'(ready),     32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // Single word 7 from the table
        for (int i = 0; i <= FL; i++) begin
            word  = tv[i].word;
            valid = tv[i].valid;
            step();
            chk($sformatf("tv%0d_out", i),   32'(out),       32'(tv[i].e_out));
            chk($sformatf("tv%0d_ov", i),    32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("tv%0d_done", i),  32'(done),      32'(tv[i].e_done));
            chk($sformatf("tv%0d_ready", i), 32'(ready),     32'(tv[i].e_ready));
        end
        valid = 1'b0;

        // Back-to-back 7 then 14 with valid held
        word = W'(7); valid = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            step();
            if (i == 0) word = W'(14);
            if (i == 2 * FL - 1) valid = 1'b0;
            chk($sformatf("b2b%0d_out", i),  32'(out), 32'(exp_bit((i < FL) ? W'(7) : W'(14), i % FL)));
            chk($sformatf("b2b%0d_ov", i),   32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_done", i), 32'(done),  32'(i % FL == FL - 1));
        end
        step();
        chk("b2b_idle_ov", 32'(out_valid), 32'd0);

        // Word change mid-frame is ignored until the final bit cycle
        word = W'(7); valid = 1'b1;
        for (int i = 0; i < FL; i++) begin
            step();
            if (i == 0) word = W'(14'h2AAA);
            chk($sformatf("mid%0d_out", i),   32'(out),   32'(exp_bit(W'(7), i)));
            chk($sformatf("mid%0d_ready", i), 32'(ready), 32'(i == FL - 1));
        end
        expect_frame(W'(14'h2AAA), "mid2aaa");

        // Reset mid-frame at bit 5
        word = W'(14'h3FFF); valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (5) step();
        chk("abort_bit5", 32'(out), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_out",   32'(out),       32'd0);
        chk("abort_ready", 32'(ready),     32'd1);
        chk("abort_ov",    32'(out_valid), 32'd0);
        chk("abort_done",  32'(done),      32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_hold_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        word = W'(14'h0155); valid = 1'b1;
        expect_frame(W'(14'h0155), "post_rst");

        // Sweep 0,7,...,497 back-to-back, compare frames and a "101" detector
        h_dut = '0; h_ref = '0; c_dut = 0; c_ref = 0;
        word = '0; valid = 1'b1;
        for (int j = 0; j <= 71; j++) begin
            wj   = W'(7 * j);
            got  = '0;
            expw = '0;
            for (int i = 0; i < FL; i++) begin
                step();
                if (i == 0) begin
                    if (j < 71) word = W'(7 * (j + 1));
                    else        valid = 1'b0;
                end
                got[i]  = out;
                expw[i] = exp_bit(wj, i);
                h_dut = {h_dut[1:0], out};
                h_ref = {h_ref[1:0], exp_bit(wj, i)};
                if (h_dut == 3'b101) c_dut++;
                if (h_ref == 3'b101) c_ref++;
            end
            chk($sformatf("sweep_w%0d", 7 * j), got, expw);
        end
        chk("sweep_det101", 32'(c_dut), 32'(c_ref));
        step();
        chk("sweep_idle_ov", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 14: number of data bits per word.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 word  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-005 valid  input  1  word is offered for transmission.
REQ-006 ready  output  1  block can accept a word this cycle.
REQ-007 out  output  1  serial bit stream, LSB first; registered.
REQ-008 out_valid  output  1  out carries a payload bit this cycle.
REQ-009 done  output  1  single-cycle pulse marking the final bit of a frame on out.

Function
REQ-010 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; word is captured into an internal shift register.
REQ-011 Latency: bit 0 of an accepted word SHALL appear on out in the cycle immediately after acceptance.
REQ-012 Each bit SHALL be held on out for exactly one clock cycle, in order word[0] .. word[WIDTH-1].
REQ-013 States SHALL be IDLE and SHIFT (plus PARITY under REQ-024).
REQ-014 IDLE -> SHIFT on acceptance. SHIFT stays for WIDTH cycles. On the last bit cycle, go to SHIFT if a new word is accepted, else go to IDLE.
REQ-015 ready SHALL be 1 in IDLE and in the final bit cycle of a frame, and 0 in all other cycles.
REQ-016 Back-to-back: a word accepted in the final bit cycle SHALL start on the next cycle with no idle gap.
REQ-017 valid asserted while ready=0 SHALL be ignored; word changes during a frame SHALL NOT affect bits in flight.
REQ-018 In IDLE, out SHALL be 0 and out_valid SHALL be 0. In SHIFT, out_valid SHALL be 1.
REQ-019 done SHALL be 1 exactly in the cycle the final frame bit is on out, and 0 otherwise.
REQ-020 The bit counter SHALL be $clog2(WIDTH+1) bits wide, count 0..WIDTH-1, and reload to 0 on every acceptance; it SHALL never wrap past WIDTH-1.

Reset
REQ-021 While rstn=0: state=IDLE, counter=0, shift register=0, out=0, out_valid=0, done=0, ready=1.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with no partial completion and no done pulse.
REQ-023 The first acceptance after reset deassertion SHALL be possible on the first rising edge with rstn=1.

Configuration
REQ-024 With macro SERIAL_TX_PARITY_EN defined, the block SHALL append one even-parity bit (XOR of all WIDTH data bits) after word[WIDTH-1], in state PARITY. Frame length becomes WIDTH+1, and ready and done move to the parity cycle.
REQ-025 Without SERIAL_TX_PARITY_EN, the frame SHALL be exactly WIDTH bits, with no PARITY state and no parity logic.

Structure
REQ-026 Package serial_tx_pkg SHALL hold the state enum type (IDLE, SHIFT, PARITY) and the default WIDTH constant (14).
REQ-027 No sub-module is required; the shift register, counter and FSM SHALL reside in serial_pattern_tx.

Verification
REQ-028 Reset, then word=14'd7 with valid for one cycle: out = 1,1,1 followed by 11 zeros over the next 14 cycles; done in cycle 14; ready=0 in cycles 1-13.
REQ-029 Words 7 then 14 with valid held continuously: 28 contiguous out_valid cycles; second frame = 0,1,1,1 then zeros; two done pulses, 14 cycles apart.
REQ-030 Sweep word = 0,7,14,...,497: the bench's reference sequence-detector models fed from out SHALL match a bit-serial golden model, with no compare errors.
REQ-031 Assert rstn=0 at bit 5 of word 14'h3FFF: out=0, ready=1, out_valid=0 immediately; no done pulse; the next word transmits cleanly.
REQ-032 Change word to 14'h2AAA mid-frame with valid=1: the current frame is unchanged; 14'h2AAA is accepted only in the final bit cycle.
REQ-033 With SERIAL_TX_PARITY_EN, word=14'd7 gives a 15th bit of 1 with done on it; word=14'd3 gives a 15th bit of 0.
